// File: rtl/hamming_rd_port_decoder.sv
// hamming_rd_port_decoder: single-outstanding read port controller with SEC-DED decode and saturating error counters
module hamming_rd_port_decoder #(
    parameter int DATA_WIDTH = 4,
    parameter int MEM_DEPTH  = 32,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int MEM_WIDTH  = 2 * ADDR_WIDTH,
    parameter int RD_LATENCY = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [MEM_WIDTH-1:0]  mem_rdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_corr,
    output logic                  resp_dbl,
    output logic [7:0]            corr_cnt,
    output logic [7:0]            dbl_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic [7:0] cw, fixed;
    logic [2:0] syn;
    logic par, dbl, capture, unused_rdata;

    assign cw = mem_rdata[7:0];
    assign unused_rdata = ^mem_rdata[MEM_WIDTH-1:8];
    assign syn = {cw[4] ^ cw[5] ^ cw[6] ^ cw[7], cw[2] ^ cw[3] ^ cw[6] ^ cw[7], cw[1] ^ cw[3] ^ cw[5] ^ cw[7]};
    assign par = ^cw;
    assign dbl = !par && syn != 3'd0;
    // odd parity marks a single flip at position syn; syn==0 lands on the overall parity bit
    assign fixed = par ? cw ^ (8'd1 << syn) : cw;
    assign capture = state == WAIT && cnt == 4'd0;
    assign mem_en = state == ISSUE;
    assign resp_valid = state == RESP;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = rd_req_valid && rd_req_ready ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = capture ? RESP : WAIT;
            default: state_nx = resp_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rd_req_ready <= 1'b0;
            mem_addr     <= '0;
            cnt          <= '0;
            resp_data    <= '0;
            resp_corr    <= 1'b0;
            resp_dbl     <= 1'b0;
            corr_cnt     <= '0;
            dbl_cnt      <= '0;
        end else begin
            state        <= state_nx;
            rd_req_ready <= state_nx == IDLE;
            if (state == IDLE && rd_req_valid && rd_req_ready)
                mem_addr <= rd_req_addr;
            cnt <= state == ISSUE ? 4'(RD_LATENCY - 1) : cnt - {3'd0, state == WAIT};
            if (capture) begin
                resp_data <= {fixed[7], fixed[6], fixed[5], fixed[3]};
                resp_corr <= par;
                resp_dbl  <= dbl;
                if (par && corr_cnt != 8'hFF)
                    corr_cnt <= corr_cnt + 8'd1;
                if (dbl && dbl_cnt != 8'hFF)
                    dbl_cnt <= dbl_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_hamming_rd_port_decoder.sv
// tb_hamming_rd_port_decoder: scoreboard bench with a fixed-latency memory model and a nearest-codeword reference decoder
module tb_hamming_rd_port_decoder;
    localparam int L = 5;
    typedef struct packed {logic [3:0] data; logic corr; logic dbl;} exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic rd_req_valid = 1'b0, rd_req_ready, mem_en, resp_valid, resp_ready = 1'b1, resp_corr, resp_dbl;
    logic [4:0] rd_req_addr = '0, mem_addr;
    logic [9:0] mem_rdata;
    logic [3:0] resp_data;
    logic [7:0] corr_cnt, dbl_cnt, cur_cw = 8'h00;
    logic v1 = 1'b0, r1, en1, rv1, rr1 = 1'b1, c1, db1;
    logic [4:0] addr1 = '0, maddr1;
    logic [9:0] rdata1;
    logic [3:0] data1;
    logic [7:0] cc1, dc1, cw1 = 8'h00;
    logic [L-1:0] sr = '0;
    logic en1_d = 1'b0;
    int checks = 0, errors = 0, cyc = 0, exp_corr = 0, exp_dbl = 0;
    exp_t sb[$];

    hamming_rd_port_decoder dut (
        .clk(clk), .rst(rst), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_corr(resp_corr), .resp_dbl(resp_dbl), .corr_cnt(corr_cnt), .dbl_cnt(dbl_cnt)
    );

    hamming_rd_port_decoder #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .rd_req_valid(v1), .rd_req_ready(r1),
        .rd_req_addr(addr1), .mem_en(en1), .mem_addr(maddr1), .mem_rdata(rdata1),
        .resp_valid(rv1), .resp_ready(rr1), .resp_data(data1),
        .resp_corr(c1), .resp_dbl(db1), .corr_cnt(cc1), .dbl_cnt(dc1)
    );

    always #5 clk = ~clk;

    // memory model: codeword is driven only in the cycle RD_LATENCY after the mem_en cycle
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        sr    <= {sr[L-2:0], mem_en};
        en1_d <= en1;
    end
    assign mem_rdata = sr[L-1] ? {2'b10, cur_cw} : {2'b01, 8'h55};
    assign rdata1    = en1_d ? {2'b10, cw1} : {2'b01, 8'h55};

    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0] c;
        c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
        c[1] = d[0] ^ d[1] ^ d[3];
        c[2] = d[0] ^ d[2] ^ d[3];
        c[4] = d[1] ^ d[2] ^ d[3];
        c[0] = ^c[7:1];
        return c;
    endfunction

    function automatic exp_t model(input logic [7:0] w);
        exp_t e;
        int best = 9;
        e.data = {w[7], w[6], w[5], w[3]};
        for (int v = 0; v < 16; v++) begin
            int h;
            h = $countones(enc(4'(v)) ^ w);
            if (h < best) begin
                best = h;
                if (h <= 1) e.data = 4'(v);
            end
        end
        e.corr = best == 1;
        e.dbl  = best >= 2;
        return e;
    endfunction

    task automatic pop_exp(output exp_t e);
        e = '0;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got 0 entries, want at least 1");
        end else begin
            e = sb.pop_front();
            if (e.corr && exp_corr < 255) exp_corr++;
            if (e.dbl && exp_dbl < 255) exp_dbl++;
        end
    endtask

    task automatic send_req(input logic [4:0] a, input logic [7:0] w, output int acc);
        bit ok = 0;
        cur_cw = w; rd_req_addr = a; rd_req_valid = 1'b1; acc = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (rd_req_ready) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (ok) begin
            acc = cyc;
            sb.push_back(model(w));
        end else begin
            checks++; errors++;
            $display("FAIL req_timeout: rd_req_ready=0, want 1");
        end
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int rc);
        bit ok = 0;
        rc = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (resp_valid) begin ok = 1; rc = cyc; end
            else begin @(posedge clk); #1; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL resp_timeout: resp_valid=0, want 1");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rd_req_ready !== 1'b1 || r1 !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b/%b, want 1/1", rd_req_ready, r1);
        end
        checks++;
        if ({mem_en, mem_addr, resp_valid, resp_data, resp_corr, resp_dbl} !== 13'd0) begin
            errors++; $display("FAIL reset_outputs: got en=%b addr=%h v=%b d=%h c=%b b=%b, want all 0",
                               mem_en, mem_addr, resp_valid, resp_data, resp_corr, resp_dbl);
        end
        checks++;
        if (corr_cnt !== 8'd0 || dbl_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d, want 0/0", corr_cnt, dbl_cnt);
        end
    endtask

    task automatic test_clean();
        int acc, rc;
        exp_t e;
        send_req(5'd3, 8'hAA, acc);
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 5'd3) begin
            errors++; $display("FAIL issue_pulse: got en=%b addr=%0d, want 1/3", mem_en, mem_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_en !== 1'b0) begin
            errors++; $display("FAIL issue_one_cycle: got mem_en=%b, want 0", mem_en);
        end
        wait_resp(rc);
        checks++;
        if (rc - acc != L + 2) begin
            errors++; $display("FAIL clean_latency: got %0d, want %0d", rc - acc, L + 2);
        end
        pop_exp(e);
        checks++;
        if ({resp_data, resp_corr, resp_dbl} !== {e.data, e.corr, e.dbl}) begin
            errors++; $display("FAIL clean_resp: got d=%h c=%b b=%b, want d=%h c=%b b=%b",
                               resp_data, resp_corr, resp_dbl, e.data, e.corr, e.dbl);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        logic [7:0] tbl [3] = '{8'h8A, 8'hAB, 8'hCA};
        for (int n = 0; n < 15; n++) begin
            int acc, rc, j;
            logic [7:0] w, m;
            exp_t e;
            if (n < 3) w = tbl[n];
            else begin
                m = '0;
                if ($urandom_range(0, 2) > 0) m[$urandom_range(0, 7)] = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    do j = $urandom_range(0, 7); while (m[j]);
                    m[j] = 1'b1;
                end
                w = enc(4'($urandom_range(0, 15))) ^ m;
            end
            send_req(5'(n), w, acc);
            wait_resp(rc);
            pop_exp(e);
            checks++;
            if ({resp_data, resp_corr, resp_dbl} !== {e.data, e.corr, e.dbl}) begin
                errors++; $display("FAIL decode_resp cw=%h: got d=%h c=%b b=%b, want d=%h c=%b b=%b",
                                   w, resp_data, resp_corr, resp_dbl, e.data, e.corr, e.dbl);
            end
            checks++;
            if (corr_cnt !== 8'(exp_corr) || dbl_cnt !== 8'(exp_dbl)) begin
                errors++; $display("FAIL decode_counters cw=%h: got %0d/%0d, want %0d/%0d",
                                   w, corr_cnt, dbl_cnt, exp_corr, exp_dbl);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int acc, rc, en_cnt = 0;
        logic [5:0] snap;
        exp_t e;
        resp_ready = 1'b0;
        send_req(5'd4, 8'h8A, acc);
        wait_resp(rc);
        pop_exp(e);
        checks++;
        if ({resp_data, resp_corr, resp_dbl} !== {e.data, e.corr, e.dbl}) begin
            errors++; $display("FAIL stall_resp: got d=%h c=%b b=%b, want d=%h c=%b b=%b",
                               resp_data, resp_corr, resp_dbl, e.data, e.corr, e.dbl);
        end
        snap = {resp_data, resp_corr, resp_dbl};
        rd_req_valid = 1'b1; rd_req_addr = 5'd7; cur_cw = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (mem_en) en_cnt++;
            checks++;
            if (resp_valid !== 1'b1 || rd_req_ready !== 1'b0 || {resp_data, resp_corr, resp_dbl} !== snap) begin
                errors++; $display("FAIL stall_hold %0d: got v=%b rdy=%b out=%h, want 1/0/%h",
                                   i, resp_valid, rd_req_ready, {resp_data, resp_corr, resp_dbl}, snap);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || rd_req_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release: got v=%b rdy=%b, want 0/1", resp_valid, rd_req_ready);
        end
        acc = cyc;
        sb.push_back(model(8'hAA));
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 5'd7 || en_cnt != 0) begin
            errors++; $display("FAIL stall_second_issue: got en=%b addr=%0d stalled_pulses=%0d, want 1/7/0",
                               mem_en, mem_addr, en_cnt);
        end
        wait_resp(rc);
        pop_exp(e);
        checks++;
        if (rc - acc != L + 2 || {resp_data, resp_corr, resp_dbl} !== {e.data, e.corr, e.dbl}) begin
            errors++; $display("FAIL second_resp: got lat=%0d d=%h c=%b b=%b, want lat=%0d d=%h c=%b b=%b",
                               rc - acc, resp_data, resp_corr, resp_dbl, L + 2, e.data, e.corr, e.dbl);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int acc, rc;
        exp_t e;
        send_req(5'd9, 8'hCA, acc);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_corr = 0; exp_dbl = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b0 || corr_cnt !== 8'd0 || dbl_cnt !== 8'd0) begin
                errors++; $display("FAIL abort_quiet %0d: got v=%b cnt=%0d/%0d, want 0 0/0",
                                   i, resp_valid, corr_cnt, dbl_cnt);
            end
        end
        send_req(5'd10, 8'hAA, acc);
        wait_resp(rc);
        pop_exp(e);
        checks++;
        if (rc - acc != L + 2 || {resp_data, resp_corr, resp_dbl} !== {e.data, e.corr, e.dbl}) begin
            errors++; $display("FAIL abort_recover: got lat=%0d d=%h c=%b b=%b, want lat=%0d d=%h c=%b b=%b",
                               rc - acc, resp_data, resp_corr, resp_dbl, L + 2, e.data, e.corr, e.dbl);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 260; n++) begin
            int acc, rc, b;
            logic [7:0] w;
            exp_t e;
            b = $urandom_range(0, 7);
            w = enc(4'($urandom_range(0, 15))) ^ (8'd1 << b);
            send_req(5'(n), w, acc);
            wait_resp(rc);
            pop_exp(e);
            checks++;
            if ({resp_data, resp_corr, resp_dbl} !== {e.data, e.corr, e.dbl} || corr_cnt !== 8'(exp_corr)) begin
                errors++; $display("FAIL sat_resp %0d: got d=%h c=%b b=%b cnt=%0d, want d=%h c=%b b=%b cnt=%0d",
                                   n, resp_data, resp_corr, resp_dbl, corr_cnt, e.data, e.corr, e.dbl, exp_corr);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (corr_cnt !== 8'd255 || dbl_cnt !== 8'd0) begin
            errors++; $display("FAIL sat_final: got %0d/%0d, want 255/0", corr_cnt, dbl_cnt);
        end
    endtask

    task automatic test_latency1();
        int acc, rc = 0;
        bit ok = 0;
        cw1 = 8'h8A; addr1 = 5'd2; v1 = 1'b1;
        for (int i = 0; i < 20 && !r1; i++) begin @(posedge clk); #1; end
        acc = cyc;
        @(posedge clk); #1;
        v1 = 1'b0;
        checks++;
        if (en1 !== 1'b1 || maddr1 !== 5'd2) begin
            errors++; $display("FAIL lat1_issue: got en=%b addr=%0d, want 1/2", en1, maddr1);
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rv1) begin ok = 1; rc = cyc; end
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!ok || rc - acc != 3) begin
            errors++; $display("FAIL lat1_latency: got valid=%b lat=%0d, want 1/3", ok, rc - acc);
        end
        checks++;
        if ({data1, c1, db1} !== {4'hB, 1'b1, 1'b0} || cc1 !== 8'd1 || dc1 !== 8'd0) begin
            errors++; $display("FAIL lat1_resp: got d=%h c=%b b=%b cnt=%0d/%0d, want d=b c=1 b=0 cnt=1/0",
                               data1, c1, db1, cc1, dc1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_decode();
        test_back_to_back();
        test_reset_abort();
        test_saturation();
        test_latency1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
